// File: rtl/numpad_scan_ctrl.sv
// numpad_scan_ctrl: 4x4 keypad column scanner with row debounce and a key-code queue.
// Latency: rows pass a 2-flop synchroniser and are sampled once per SETTLE_CYCLES; key_valid rises the clock after a push.
// Backpressure: valid/ready FIFO toward the core; a confirmed key arriving while the queue is full is dropped and flagged on overflow.
// Optional build macro NUMPAD_AUTOREPEAT_EN adds held-key auto-repeat (REPEAT_DELAY / REPEAT_RATE in sample ticks).
module numpad_scan_ctrl #(
   parameter int SETTLE_CYCLES    = 8,
   parameter int DEBOUNCE_SAMPLES = 4,
   parameter int FIFO_DEPTH       = 4
`ifdef NUMPAD_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY     = 32,
   parameter int REPEAT_RATE      = 8
`endif
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [3:0]                  rows,
   output logic [3:0]                  columns,
   output logic                        key_valid,
   output logic [3:0]                  key_code,
   input  logic                        key_ready,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int SW = $clog2(SETTLE_CYCLES);
   localparam int PW = $clog2(FIFO_DEPTH);

   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
   // Counter value whose increment reaches DEBOUNCE_SAMPLES.
   localparam logic [3:0]    DEB_LAST    = 4'(DEBOUNCE_SAMPLES - 1);
   localparam logic [PW:0]   DEPTH_L     = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0]   CNT_ONE     = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE     = PW'(1);

   localparam logic [1:0] ST_SCAN     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_HELD     = 2'd2;

   // Synchroniser and scan state
   logic [3:0]    rows_meta_q, rows_sync_q;
   logic [SW-1:0] settle_q, settle_d;
   logic [1:0]    state_q, state_d;
   logic [1:0]    col_q, col_d;
   logic [3:0]    columns_q, columns_d;
   logic [3:0]    cand_q, cand_d;
   logic [3:0]    deb_cnt_q, deb_cnt_d;
   logic [3:0]    rel_cnt_q, rel_cnt_d;

   logic          tick;
   logic          row_single;
   logic [1:0]    row_idx;
   logic          push;
   logic          advance;

`ifdef NUMPAD_AUTOREPEAT_EN
   localparam logic [15:0] REP_DELAY_L = 16'(REPEAT_DELAY);
   localparam logic [15:0] REP_RATE_L  = 16'(REPEAT_RATE);
   logic [15:0]   rep_cnt_q, rep_cnt_d;
   logic          rep_phase_q, rep_phase_d;   // 0: waiting for first repeat, 1: repeating at RATE
   logic [15:0]   rep_nxt;
`endif

   // FIFO state
   logic [3:0]    mem_q [FIFO_DEPTH];
   logic [3:0]    mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          pop;
   logic          full;
   logic          wr_en;

   // Two-flop synchroniser for the asynchronous row lines
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rows_meta_q <= 4'd0;
         rows_sync_q <= 4'd0;
      end else begin
         rows_meta_q <= rows;
         rows_sync_q <= rows_meta_q;
      end
   end

   // Row classification: a single set bit is a key, zero or ghosted multi-bit is "none"
   always_comb begin
      row_single = 1'b0;
      row_idx    = 2'd0;
      case (rows_sync_q)
         4'b0001: begin row_single = 1'b1; row_idx = 2'd0; end
         4'b0010: begin row_single = 1'b1; row_idx = 2'd1; end
         4'b0100: begin row_single = 1'b1; row_idx = 2'd2; end
         4'b1000: begin row_single = 1'b1; row_idx = 2'd3; end
         default: begin row_single = 1'b0; row_idx = 2'd0; end
      endcase
   end

   // Column changes only happen on a tick, so wrapping the counter there also restarts settling
   assign tick     = (settle_q == SETTLE_LAST);
   assign settle_d = tick ? '0 : settle_q + SETTLE_ONE;

   // Scan / debounce / held sequencer, evaluated once per sample tick
   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      deb_cnt_d = deb_cnt_q;
      rel_cnt_d = rel_cnt_q;
      push      = 1'b0;
      advance   = 1'b0;
`ifdef NUMPAD_AUTOREPEAT_EN
      rep_cnt_d   = rep_cnt_q;
      rep_phase_d = rep_phase_q;
      rep_nxt     = rep_cnt_q + 16'd1;
`endif
      if (tick) begin
         case (state_q)
            ST_SCAN: begin
               if (row_single) begin
                  cand_d = {col_q, row_idx};
                  if (DEB_LAST == 4'd0) begin
                     push      = 1'b1;
                     state_d   = ST_HELD;
                     rel_cnt_d = 4'd0;
`ifdef NUMPAD_AUTOREPEAT_EN
                     rep_cnt_d   = 16'd0;
                     rep_phase_d = 1'b0;
`endif
                  end else begin
                     deb_cnt_d = 4'd1;
                     state_d   = ST_DEBOUNCE;
                  end
               end else begin
                  advance = 1'b1;
               end
            end
            ST_DEBOUNCE: begin
               if (row_single && (row_idx == cand_q[1:0])) begin
                  if (deb_cnt_q == DEB_LAST) begin
                     push      = 1'b1;
                     state_d   = ST_HELD;
                     rel_cnt_d = 4'd0;
`ifdef NUMPAD_AUTOREPEAT_EN
                     rep_cnt_d   = 16'd0;
                     rep_phase_d = 1'b0;
`endif
                  end else begin
                     deb_cnt_d = deb_cnt_q + 4'd1;
                  end
               end else begin
                  state_d = ST_SCAN;
                  advance = 1'b1;
               end
            end
            ST_HELD: begin
               if (row_single) begin
                  rel_cnt_d = 4'd0;
               end else if (rel_cnt_q == DEB_LAST) begin
                  rel_cnt_d = 4'd0;
                  state_d   = ST_SCAN;
                  advance   = 1'b1;
               end else begin
                  rel_cnt_d = rel_cnt_q + 4'd1;
               end
`ifdef NUMPAD_AUTOREPEAT_EN
               if (row_single && (row_idx == cand_q[1:0])) begin
                  if (rep_nxt == (rep_phase_q ? REP_RATE_L : REP_DELAY_L)) begin
                     push        = 1'b1;
                     rep_cnt_d   = 16'd0;
                     rep_phase_d = 1'b1;
                  end else begin
                     rep_cnt_d = rep_nxt;
                  end
               end else begin
                  rep_cnt_d   = 16'd0;
                  rep_phase_d = 1'b0;
               end
`endif
            end
            default: begin
               state_d = ST_SCAN;
            end
         endcase
      end
      col_d     = advance ? col_q + 2'd1 : col_q;
      columns_d = 4'b0001 << col_d;
   end

   // Sequencer registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         settle_q  <= '0;
         state_q   <= ST_SCAN;
         col_q     <= 2'd0;
         columns_q <= 4'b0001;
         cand_q    <= 4'd0;
         deb_cnt_q <= 4'd0;
         rel_cnt_q <= 4'd0;
      end else begin
         settle_q  <= settle_d;
         state_q   <= state_d;
         col_q     <= col_d;
         columns_q <= columns_d;
         cand_q    <= cand_d;
         deb_cnt_q <= deb_cnt_d;
         rel_cnt_q <= rel_cnt_d;
      end
   end

`ifdef NUMPAD_AUTOREPEAT_EN
   // Auto-repeat registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rep_cnt_q   <= 16'd0;
         rep_phase_q <= 1'b0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_phase_q <= rep_phase_d;
      end
   end
`endif

   // FIFO control: a pop in the same cycle frees the slot a full-queue push needs
   assign pop   = key_ready && (count_q != '0);
   assign full  = (count_q == DEPTH_L);
   assign wr_en = push && (!full || pop);

   // FIFO next-state: storage, pointers, occupancy and drop flag
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = cand_d;
      end
      wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      if (wr_en && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!wr_en && pop) begin
         count_d = count_q - CNT_ONE;
      end
      ovf_d = push && full && !pop;
   end

   // FIFO registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 4'd0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   assign columns    = columns_q;
   assign key_valid  = (count_q != '0);
   assign key_code   = mem_q[rd_ptr_q];
   assign overflow   = ovf_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_numpad_scan_ctrl.sv
// Bench for numpad_scan_ctrl: keypad model drives rows from the column strobes,
// expected key codes queue up as keys are pressed and are compared as the DUT pops them.
module tb_numpad_scan_ctrl;

   localparam int SETTLE = 8;
   localparam int DEB    = 4;
   localparam int DEPTH  = 4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] rows;
   logic [3:0] columns;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready = 1'b0;
   logic       overflow;
   logic [2:0] fifo_count;

   // keypad model: a pressed key connects its column strobe to its row line(s)
   logic       key_on = 1'b0;
   logic [1:0] key_c = 2'd0;
   logic [3:0] key_rows = 4'd0;

   int n_checks = 0;
   int n_fail   = 0;
   int ovf_pulses = 0;
   logic [3:0] exp_q[$];

   numpad_scan_ctrl #(
      .SETTLE_CYCLES(SETTLE),
      .DEBOUNCE_SAMPLES(DEB),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .rows(rows),
      .columns(columns),
      .key_valid(key_valid),
      .key_code(key_code),
      .key_ready(key_ready),
      .overflow(overflow),
      .fifo_count(fifo_count)
   );

   always #5 clock = ~clock;

   always_comb rows = (key_on && columns[key_c]) ? key_rows : 4'b0000;

   always @(negedge clock) begin
      if (reset_n && overflow) ovf_pulses <= ovf_pulses + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic do_reset();
      key_on = 1'b0;
      key_ready = 1'b0;
      exp_q.delete();
      @(negedge clock);
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic press(input logic [1:0] c, input logic [3:0] r);
      key_c = c;
      key_rows = r;
      key_on = 1'b1;
   endtask

   task automatic wait_count(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (int'(fifo_count) == target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_col_leave(input logic [3:0] col, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (columns != col) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_col_enter(input logic [3:0] col, input int budget, output bit ok);
      logic [3:0] prev;
      ok = 1'b0;
      prev = columns;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock);
         if (columns == col && prev != col) begin
            ok = 1'b1;
            break;
         end
         prev = columns;
      end
   endtask

   // pops the head when valid; returns the code seen before the pop edge
   task automatic pop_one(output logic [3:0] code, output bit ok);
      ok = 1'b0;
      code = 4'd0;
      for (int i = 0; i < 50; i++) begin
         if (key_valid) begin
            code = key_code;
            ok = 1'b1;
            key_ready = 1'b1;
            @(negedge clock);
            key_ready = 1'b0;
            break;
         end
         @(negedge clock);
      end
   endtask

   // press a key, wait for the queue to reach target, release, wait for the scan to move on
   task automatic press_and_release(input logic [1:0] c, input logic [3:0] r, input int target,
                                    input string name);
      bit ok;
      press(c, r);
      wait_count(target, 400, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s_push: fifo_count %0d, required %0d", name, fifo_count, target);
      end
      key_on = 1'b0;
      wait_col_leave(4'b0001 << c, 200, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s_release: columns stuck at %b", name, columns);
      end
   endtask

   task automatic test_reset();
      key_on = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++; if (columns !== 4'b0001) begin n_fail++; $display("FAIL reset_columns: %b, required 0001", columns); end
      n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: %b, required 0", key_valid); end
      n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL reset_key_code: %0d, required 0", key_code); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: %b, required 0", overflow); end
      n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count: %0d, required 0", fifo_count); end
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      n_checks++; if (columns !== 4'b0001) begin n_fail++; $display("FAIL post_reset_columns: %b, required 0001", columns); end
   endtask

   task automatic test_single_key();
      int cycles;
      bit ok;
      logic [3:0] code;
      logic [3:0] seq [3];
      seq[0] = 4'b0100; seq[1] = 4'b1000; seq[2] = 4'b0001;
      do_reset();
      press(2'd1, 4'b0100);           // key 8
      exp_q.push_back(4'd6);
      cycles = 0;
      while (!key_valid && cycles < 80) begin
         @(negedge clock);
         cycles++;
      end
      n_checks++;
      if (!key_valid || cycles > 58) begin
         n_fail++;
         $display("FAIL key8_latency: key_valid=%b after %0d clocks, required 1 within 58", key_valid, cycles);
      end
      key_on = 1'b0;
      n_checks++;
      if (columns !== 4'b0010) begin n_fail++; $display("FAIL key8_held_column: %b, required 0010", columns); end
      pop_one(code, ok);
      n_checks++;
      if (!ok || code !== exp_q[0]) begin
         n_fail++;
         $display("FAIL key8_code: got %0d (valid %b), required %0d", code, ok, exp_q[0]);
      end
      void'(exp_q.pop_front());
      for (int k = 0; k < 3; k++) begin
         wait_col_leave(k == 0 ? 4'b0010 : seq[k-1], 200, ok);
         n_checks++;
         if (!ok || columns !== seq[k]) begin
            n_fail++;
            $display("FAIL resume_scan_%0d: columns %b, required %b", k, columns, seq[k]);
         end
      end
   endtask

   task automatic test_bounce();
      bit ok;
      logic [3:0] code;
      do_reset();
      key_c = 2'd2;
      key_rows = 4'b0100;             // key 9 -> code 10
      exp_q.push_back(4'd10);
      for (int t = 0; t < 10; t++) begin
         key_on = ~key_on;
         repeat (SETTLE) @(negedge clock);
      end
      key_on = 1'b1;
      wait_count(1, 400, ok);
      repeat (100) @(negedge clock);
      n_checks++;
      if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL bounce_count: %0d, required 1", fifo_count); end
      key_on = 1'b0;
      pop_one(code, ok);
      n_checks++;
      if (!ok || code !== exp_q[0]) begin
         n_fail++;
         $display("FAIL bounce_code: got %0d (valid %b), required %0d", code, ok, exp_q[0]);
      end
      void'(exp_q.pop_front());
   endtask

   task automatic test_ghost();
      int changes;
      logic [3:0] prev;
      do_reset();
      press(2'd3, 4'b0011);
      prev = columns;
      changes = 0;
      for (int i = 0; i < 240; i++) begin
         @(negedge clock);
         if (columns != prev) changes++;
         prev = columns;
      end
      key_on = 1'b0;
      n_checks++;
      if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL ghost_count: %0d, required 0", fifo_count); end
      n_checks++;
      if (changes < 25) begin n_fail++; $display("FAIL ghost_rotation: %0d column changes, required at least 25", changes); end
   endtask

   task automatic test_overflow();
      int snap;
      bit ok;
      logic [3:0] code;
      do_reset();
      snap = ovf_pulses;
      exp_q.push_back(4'd0);  press_and_release(2'd0, 4'b0001, 1, "key1");
      exp_q.push_back(4'd4);  press_and_release(2'd1, 4'b0001, 2, "key2");
      exp_q.push_back(4'd8);  press_and_release(2'd2, 4'b0001, 3, "key3");
      exp_q.push_back(4'd12); press_and_release(2'd3, 4'b0001, 4, "keyA");
      press(2'd3, 4'b0010);           // key B, dropped
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (ovf_pulses != snap) begin ok = 1'b1; break; end
      end
      key_on = 1'b0;
      repeat (80) @(negedge clock);
      n_checks++;
      if (!ok || ovf_pulses - snap != 1) begin
         n_fail++;
         $display("FAIL overflow_pulses: %0d, required 1", ovf_pulses - snap);
      end
      n_checks++;
      if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL overflow_count: %0d, required 4", fifo_count); end
      while (exp_q.size() > 0) begin
         pop_one(code, ok);
         n_checks++;
         if (!ok || code !== exp_q[0]) begin
            n_fail++;
            $display("FAIL overflow_drain: got %0d (valid %b), required %0d", code, ok, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      n_checks++;
      if (key_valid !== 1'b0) begin n_fail++; $display("FAIL overflow_empty: key_valid %b, required 0", key_valid); end
   endtask

   task automatic test_push_pop_full();
      int snap;
      bit ok;
      logic [3:0] code;
      do_reset();
      exp_q.push_back(4'd0);  press_and_release(2'd0, 4'b0001, 1, "fill1");
      exp_q.push_back(4'd4);  press_and_release(2'd1, 4'b0001, 2, "fill2");
      exp_q.push_back(4'd8);  press_and_release(2'd2, 4'b0001, 3, "fill3");
      exp_q.push_back(4'd12); press_and_release(2'd3, 4'b0001, 4, "fill4");
      snap = ovf_pulses;
      wait_col_enter(4'b0100, 200, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL pp_sync: column 0100 not reached, columns %b", columns); end
      press(2'd2, 4'b0010);           // key 6 -> code 9, push lands DEB*SETTLE clocks after the column change
      exp_q.push_back(4'd9);
      repeat (DEB*SETTLE - 1) @(negedge clock);
      code = key_code;
      key_ready = 1'b1;
      @(negedge clock);
      key_ready = 1'b0;
      n_checks++;
      if (code !== exp_q[0]) begin n_fail++; $display("FAIL pp_head: got %0d, required %0d", code, exp_q[0]); end
      void'(exp_q.pop_front());
      n_checks++;
      if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL pp_count: %0d, required 4", fifo_count); end
      key_on = 1'b0;
      repeat (2) @(negedge clock);
      n_checks++;
      if (ovf_pulses != snap) begin n_fail++; $display("FAIL pp_overflow: %0d pulses, required 0", ovf_pulses - snap); end
      while (exp_q.size() > 0) begin
         pop_one(code, ok);
         n_checks++;
         if (!ok || code !== exp_q[0]) begin
            n_fail++;
            $display("FAIL pp_drain: got %0d (valid %b), required %0d", code, ok, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_autorepeat();
      int got;
      int rel_at;
      int expect_n;
      do_reset();
`ifdef NUMPAD_AUTOREPEAT_EN
      expect_n = 5;
`else
      expect_n = 1;
`endif
      for (int k = 0; k < expect_n; k++) exp_q.push_back(4'd5);
      key_ready = 1'b1;
      press(2'd1, 4'b0010);           // key 5
      got = 0;
      rel_at = -1;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clock);
         if (key_valid) begin
            n_checks++;
            if (exp_q.size() == 0 || key_code !== exp_q[0]) begin
               n_fail++;
               $display("FAIL repeat_code: got %0d, queued expectations %0d", key_code, exp_q.size());
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (got == 0) rel_at = i + 475;   // hold for 59 more sample ticks after the first push
            got++;
         end
         if (i == rel_at) key_on = 1'b0;
      end
      key_ready = 1'b0;
      n_checks++;
      if (got != expect_n) begin n_fail++; $display("FAIL repeat_total: %0d codes, required %0d", got, expect_n); end
   endtask

   task automatic test_reset_mid_press();
      bit ok;
      logic [3:0] code;
      do_reset();
      press(2'd0, 4'b1000);           // key 0 -> code 3
      wait_count(1, 400, ok);
      @(negedge clock);
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      n_checks++;
      if (fifo_count !== 3'd0 || key_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_clear: fifo_count %0d key_valid %b, required 0 0", fifo_count, key_valid);
      end
      exp_q.delete();
      exp_q.push_back(4'd3);
      reset_n = 1'b1;
      wait_count(1, 400, ok);
      repeat (100) @(negedge clock);
      n_checks++;
      if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL midreset_repush: %0d, required 1", fifo_count); end
      key_on = 1'b0;
      pop_one(code, ok);
      n_checks++;
      if (!ok || code !== exp_q[0]) begin
         n_fail++;
         $display("FAIL midreset_code: got %0d (valid %b), required %0d", code, ok, exp_q[0]);
      end
      void'(exp_q.pop_front());
   endtask

   initial begin
      test_reset();
      test_single_key();
      test_bounce();
      test_ghost();
      test_overflow();
      test_push_pop_full();
      test_autorepeat();
      test_reset_mid_press();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/numpad_scan_ctrl.md
Name: numpad_scan_ctrl

Overview:
- Sequencer for the 4x4 calculator keypad.
- Drives one-hot column strobes, samples the row lines, and debounces the hit.
- Converts each confirmed press into a 4-bit key code (code = col*4 + row; 1=0, 4=1, 7=2, 0=3, 2=4 ... D=15).
- Queues codes in a small FIFO with a valid/ready interface to the calculator core, so no key is lost while the core is busy.

Parameters:
- SETTLE_CYCLES, 8: clocks per sample period after a column change (must be >= 3, to cover the 2-flop synchroniser).
- DEBOUNCE_SAMPLES, 4: consecutive identical samples needed to accept a press, and consecutive empty samples needed to accept a release (1..15).
- FIFO_DEPTH, 4: key-code queue depth, power of two, 2..16.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rows  in  4  raw keypad row lines, active high, asynchronous; passed through a 2-flop synchroniser before any use.
- columns  out  4  one-hot column drive; bit n is high while column n is scanned.
- key_valid  out  1  FIFO non-empty; key_code is valid.
- key_code  out  4  FIFO head code (first-word-fall-through).
- key_ready  in  1  consumer accepts the head when key_valid && key_ready on a clock edge.
- overflow  out  1  one-cycle pulse when a confirmed key is dropped because the FIFO is full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued codes.

Behaviour:
- Reset (async assert, sync release): state=SCAN, col=0, columns=4'b0001, settle counter=0, debounce/release counters=0, FIFO empty, key_valid=0, key_code=0, overflow=0, fifo_count=0.
- Sample tick: the settle counter runs 0..SETTLE_CYCLES-1 and restarts on every column change. A sample tick occurs when the counter equals SETTLE_CYCLES-1; the synchronised rows value is sampled there.
- Row classification at each tick:
  - "none": rows==0.
  - "single r": exactly one bit r set.
  - "multi": two or more bits set (ghosting). Multi is always treated as none.
- FSM:
  - SCAN:
    - On none: col <= col+1 (3 wraps to 0) and the settle counter restarts.
    - On single r: cand <= col*4+r, deb_cnt <= 1, go to DEBOUNCE. The column is held.
  - DEBOUNCE:
    - Single with the same r: deb_cnt++.
    - deb_cnt reaching DEBOUNCE_SAMPLES: push cand, go to HELD, rel_cnt <= 0.
    - Anything else: go to SCAN, advance the column, no push.
    - With DEBOUNCE_SAMPLES=1 the push happens on the SCAN tick itself, and the FSM goes straight to HELD.
  - HELD:
    - Column held. A none tick increments rel_cnt; any non-none tick clears it.
    - rel_cnt reaching DEBOUNCE_SAMPLES: go to SCAN and advance the column.
    - Only one push per press. Keys pressed in other columns while held are ignored.
- columns is registered, always exactly one-hot, and equals 1<<col.
- FIFO:
  - Push when the debounce completes.
  - Push while full with no pop in the same cycle: code dropped, overflow=1 for that cycle.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: impossible by construction (key_valid=0 when empty). The push lands and key_valid rises on the next cycle.
  - Pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a key pushed into an empty FIFO asserts key_valid on the clock after the push edge.
- Worst-case press-to-push time from an idle scan is (4 + DEBOUNCE_SAMPLES - 1) * SETTLE_CYCLES + 2 synchroniser clocks.
- Reset mid-press: everything clears. A key still held after release of reset is detected fresh and pushed once.

Optional Feature:
- Macro: NUMPAD_AUTOREPEAT_EN.
- When defined, adds parameters REPEAT_DELAY (default 32) and REPEAT_RATE (default 8), both in sample ticks.
- In HELD, while the same single r is sampled:
  - A repeat counter counts ticks.
  - After REPEAT_DELAY ticks, cand is pushed again.
  - It is then re-pushed every REPEAT_RATE ticks.
  - Full FIFO follows the normal overflow rule.
- Any non-matching tick resets the repeat counter.
- When undefined: exactly one push per press, no repeat logic present.

Test Plan:
- Reset, then hold row 2 high only while columns=4'b0010 (key 8), SETTLE=8, DEB=4 -> key_code=6 and key_valid=1 within 58 clocks; after release, columns resumes cycling 0100, 1000, 0001.
- Key bounces (row toggles on every sample tick for 10 ticks) then holds steady -> exactly one push of the correct code; fifo_count=1.
- Rows 0 and 1 high together in column 3 -> no push, columns keeps rotating, fifo_count stays 0.
- key_ready=0; press keys 1, 2, 3, A, B in sequence (FIFO_DEPTH=4) -> fifo_count=4, one overflow pulse on the fifth push; then key_ready=1 -> codes 0, 4, 8, 12 popped in order, key_valid drops.
- FIFO full with a push and pop in the same cycle -> count stays 4, no overflow, new code queued at the tail.
- With NUMPAD_AUTOREPEAT_EN, hold key 5 for 60 ticks (DELAY=32, RATE=8) -> codes 5, 5, 5, 5, 5 (first push + repeats at ticks 32, 40, 48, 56); without the macro -> a single 5.
